// File: rtl/rom_fetch_ctrl_pkg.sv
// Shared fetch types and constants for the ROM instruction-fetch controller.
// Optional build macro FETCH_MISALIGN_CHK_EN is consumed by rom_fetch_ctrl.
package ifetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int ADDR_LSB    = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/rom_fetch_ctrl_fifo.sv
// Flushable shift-register FIFO of fetch entries; entry 0 is the registered head.
// Flush beats push; push and pop may coincide at any occupancy.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic [CW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_r [DEPTH];
  fetch_entry_t mem_s [DEPTH];
  logic [CW:0]  count_r;
  logic [CW:0]  wr_idx_s;
  logic         pop_s;

  // Shift on pop, then drop the pushed entry into the first free slot.
  always_comb begin
    pop_s    = pop_i & (count_r != {(CW+1){1'b0}});
    wr_idx_s = count_r - {{CW{1'b0}}, pop_s};
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (pop_s) begin
        mem_s[i] = mem_r[i+1];
      end else begin
        mem_s[i] = mem_r[i];
      end
    end
    mem_s[DEPTH-1] = mem_r[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (push_i && (wr_idx_s == (CW+1)'(i))) begin
        mem_s[i] = din_i;
      end else begin
        mem_s[i] = mem_s[i];
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= {(CW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush_i) begin
      count_r <= {(CW+1){1'b0}};
    end else begin
      count_r <= count_r + {{CW{1'b0}}, push_i} - {{CW{1'b0}}, pop_s};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_s[i];
      end
    end
  end

  assign head_o  = mem_r[0];
  assign count_o = count_r;
  assign full_o  = (count_r == (CW+1)'(DEPTH));
  assign empty_o = (count_r == {(CW+1){1'b0}});

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch initiator for a 1-cycle sync-read ROM with credit-based issue and redirect flush.
// Build macro FETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect trap.
module rom_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] jmp_addr_i,
  input  logic        jmp_valid_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_rdata_i,
  output logic        fetch_misaligned_o
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int OW = CW + 2;
  localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

  logic [31:0]  pc_r;
  logic         inflight_r;
  logic [31:0]  inflight_addr_r;
  logic         misaligned_r;

  logic         pop_s;
  logic         push_s;
  logic         issue_s;
  logic         credit_s;
  logic [OW-1:0] occ_s;
  logic [CW:0]  count_s;
  logic         full_s;
  logic         empty_s;
  fetch_entry_t head_s;
  fetch_entry_t push_entry_s;

  // Issue credit, capture and redirect decode.
  always_comb begin
    pop_s        = ~empty_s & instr_ready_i;
    push_s       = inflight_r & ~jmp_valid_i;
    push_entry_s = '{addr: inflight_addr_r, instr: rom_rdata_i};
    rom_addr_o   = jmp_valid_i ? word_align(jmp_addr_i) : pc_r;
    occ_s        = OW'(count_s) - OW'(pop_s) + OW'(inflight_r);
    if (full_s) begin
      credit_s = pop_s & ~inflight_r;
    end else begin
      credit_s = (occ_s < DEPTH_W);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    if (jmp_valid_i) begin
      issue_s = (jmp_addr_i[1:0] == 2'b00);
    end else begin
      issue_s = credit_s & ~misaligned_r;
    end
`else
    if (jmp_valid_i) begin
      issue_s = 1'b1;
    end else begin
      issue_s = credit_s;
    end
`endif
  end

  // PC, in-flight tracking and the sticky misalign flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_r            <= BOOT_ADDR;
      inflight_r      <= 1'b0;
      inflight_addr_r <= 32'h0000_0000;
      misaligned_r    <= 1'b0;
    end else begin
      if (issue_s) begin
        inflight_r      <= 1'b1;
        inflight_addr_r <= rom_addr_o;
        pc_r            <= rom_addr_o + 32'(INSTR_BYTES);
      end else begin
        inflight_r <= 1'b0;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (jmp_valid_i) begin
        misaligned_r <= (jmp_addr_i[1:0] != 2'b00);
      end else begin
        misaligned_r <= misaligned_r;
      end
`else
      misaligned_r <= 1'b0;
`endif
    end
  end

`ifndef FETCH_MISALIGN_CHK_EN
  logic unused_s;
  assign unused_s = ^jmp_addr_i[1:0];
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (jmp_valid_i),
    .din_i   (push_entry_s),
    .head_o  (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  assign instr_o            = head_s.instr;
  assign instr_addr_o       = head_s.addr;
  assign instr_valid_o      = ~empty_s;
  assign fetch_misaligned_o = misaligned_r;

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed self-checking bench for rom_fetch_ctrl; two instances cover low and near-wrap boot addresses.
module tb_rom_fetch_ctrl;

  logic        clk = 1'b0;
  int          nvec = 0;
  int          nmiss = 0;

  logic        rst, rdy, jv;
  logic [31:0] ja;
  logic [31:0] instr, iaddr, raddr, rdata;
  logic        ivalid, mis;

  logic        rst_h, rdy_h, jv_h;
  logic [31:0] ja_h;
  logic [31:0] instr_h, iaddr_h, raddr_h, rdata_h;
  logic        ivalid_h, mis_h;

  always #5 clk = ~clk;

  // ROM models: word i holds value i, one cycle read latency.
  always_ff @(posedge clk) begin
    rdata   <= {2'b00, raddr[31:2]};
    rdata_h <= {2'b00, raddr_h[31:2]};
  end

  rom_fetch_ctrl #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .jmp_addr_i(ja), .jmp_valid_i(jv),
    .instr_o(instr), .instr_addr_o(iaddr), .instr_valid_o(ivalid),
    .instr_ready_i(rdy), .rom_addr_o(raddr), .rom_rdata_i(rdata),
    .fetch_misaligned_o(mis)
  );

  rom_fetch_ctrl #(.BOOT_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_hi (
    .clk_i(clk), .rst_i(rst_h), .jmp_addr_i(ja_h), .jmp_valid_i(jv_h),
    .instr_o(instr_h), .instr_addr_o(iaddr_h), .instr_valid_o(ivalid_h),
    .instr_ready_i(rdy_h), .rom_addr_o(raddr_h), .rom_rdata_i(rdata_h),
    .fetch_misaligned_o(mis_h)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; jv = 1'b0; ja = 32'h0000_0000;
    tick(); tick(); tick();
    nvec++;
    if (ivalid !== 1'b0 || instr !== 32'h0 || iaddr !== 32'h0) begin
      nmiss++;
      $display("FAIL reset_outs got v=%b i=%h a=%h exp v=0 i=0 a=0", ivalid, instr, iaddr);
    end
    nvec++;
    if (raddr !== 32'h0000_0000 || mis !== 1'b0) begin
      nmiss++;
      $display("FAIL reset_rom got rom=%h mis=%b exp rom=0 mis=0", raddr, mis);
    end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    tick();
    nvec++;
    if (ivalid !== 1'b0) begin
      nmiss++;
      $display("FAIL stream_lat1 got v=%b exp 0", ivalid);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      nvec++;
      if (ivalid !== 1'b1 || iaddr !== 32'(4 * k) || instr !== 32'(k)) begin
        nmiss++;
        $display("FAIL stream k=%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h",
                 k, ivalid, iaddr, instr, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_stall();
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      nvec++;
      if (ivalid !== 1'b1 || iaddr !== 32'h1C || instr !== 32'd7 || raddr !== 32'h24) begin
        nmiss++;
        $display("FAIL stall c=%0d got v=%b a=%h i=%h rom=%h exp v=1 a=1c i=7 rom=24",
                 c, ivalid, iaddr, instr, raddr);
      end
    end
    rdy = 1'b1;
    for (int k = 8; k < 13; k++) begin
      tick();
      nvec++;
      if (ivalid !== 1'b1 || iaddr !== 32'(4 * k) || instr !== 32'(k)) begin
        nmiss++;
        $display("FAIL resume k=%0d got v=%b a=%h i=%h exp a=%h i=%h",
                 k, ivalid, iaddr, instr, 32'(4 * k), 32'(k));
      end
    end
  endtask

  task automatic test_redirect_full();
    rdy = 1'b0;
    tick(); tick(); tick();
    jv = 1'b1; ja = 32'h0000_0040;
    #1;
    nvec++;
    if (raddr !== 32'h40) begin
      nmiss++;
      $display("FAIL full_jmp_rom got %h exp 00000040", raddr);
    end
    tick();
    jv = 1'b0;
    nvec++;
    if (ivalid !== 1'b0) begin
      nmiss++;
      $display("FAIL full_flush got v=%b exp 0", ivalid);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h40 || instr !== 32'h10) begin
      nmiss++;
      $display("FAIL full_tgt got v=%b a=%h i=%h exp v=1 a=40 i=10", ivalid, iaddr, instr);
    end
    rdy = 1'b1;
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h44 || instr !== 32'h11) begin
      nmiss++;
      $display("FAIL full_next got v=%b a=%h i=%h exp v=1 a=44 i=11", ivalid, iaddr, instr);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h48) begin
      nmiss++;
      $display("FAIL full_next2 got v=%b a=%h exp v=1 a=48", ivalid, iaddr);
    end
  endtask

  task automatic test_redirect_pop();
    jv = 1'b1; ja = 32'h0000_0010;
    tick();
    jv = 1'b0;
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h10) begin
      nmiss++;
      $display("FAIL pop_setup got v=%b a=%h exp v=1 a=10", ivalid, iaddr);
    end
    jv = 1'b1; ja = 32'h0000_0080;
    tick();
    jv = 1'b0;
    nvec++;
    if (ivalid !== 1'b0) begin
      nmiss++;
      $display("FAIL pop_flush got v=%b a=%h exp v=0", ivalid, iaddr);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h80 || instr !== 32'h20) begin
      nmiss++;
      $display("FAIL pop_tgt got v=%b a=%h i=%h exp v=1 a=80 i=20", ivalid, iaddr, instr);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h84) begin
      nmiss++;
      $display("FAIL pop_next got v=%b a=%h exp v=1 a=84", ivalid, iaddr);
    end
  endtask

  task automatic test_misalign();
    jv = 1'b1; ja = 32'h0000_0042;
    tick();
    jv = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    for (int c = 0; c < 4; c++) begin
      nvec++;
      if (ivalid !== 1'b0 || mis !== 1'b1) begin
        nmiss++;
        $display("FAIL mis_trap c=%0d got v=%b mis=%b exp v=0 mis=1", c, ivalid, mis);
      end
      tick();
    end
    jv = 1'b1; ja = 32'h0000_0100;
    tick();
    jv = 1'b0;
    nvec++;
    if (mis !== 1'b0 || ivalid !== 1'b0) begin
      nmiss++;
      $display("FAIL mis_clear got v=%b mis=%b exp v=0 mis=0", ivalid, mis);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h100 || instr !== 32'h40) begin
      nmiss++;
      $display("FAIL mis_resume got v=%b a=%h i=%h exp v=1 a=100 i=40", ivalid, iaddr, instr);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h104) begin
      nmiss++;
      $display("FAIL mis_resume2 got v=%b a=%h exp v=1 a=104", ivalid, iaddr);
    end
`else
    nvec++;
    if (ivalid !== 1'b0 || mis !== 1'b0) begin
      nmiss++;
      $display("FAIL mis_ign1 got v=%b mis=%b exp v=0 mis=0", ivalid, mis);
    end
    tick();
    nvec++;
    if (ivalid !== 1'b1 || iaddr !== 32'h40 || instr !== 32'h10 || mis !== 1'b0) begin
      nmiss++;
      $display("FAIL mis_ign2 got v=%b a=%h i=%h mis=%b exp v=1 a=40 i=10 mis=0",
               ivalid, iaddr, instr, mis);
    end
`endif
  endtask

  task automatic test_wrap_reset();
    logic [31:0] ea [4];
    ea[0] = 32'hFFFF_FFF8; ea[1] = 32'hFFFF_FFFC; ea[2] = 32'h0000_0000; ea[3] = 32'h0000_0004;
    rst_h = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      nvec++;
      if (ivalid_h !== 1'b1 || iaddr_h !== ea[k] || instr_h !== {2'b00, ea[k][31:2]}) begin
        nmiss++;
        $display("FAIL wrap k=%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h",
                 k, ivalid_h, iaddr_h, instr_h, ea[k], {2'b00, ea[k][31:2]});
      end
    end
    rst_h = 1'b1;
    tick();
    nvec++;
    if (ivalid_h !== 1'b0 || instr_h !== 32'h0 || iaddr_h !== 32'h0 || raddr_h !== 32'hFFFF_FFF8) begin
      nmiss++;
      $display("FAIL wrap_rst got v=%b i=%h a=%h rom=%h exp v=0 i=0 a=0 rom=fffffff8",
               ivalid_h, instr_h, iaddr_h, raddr_h);
    end
    rst_h = 1'b0;
    tick();
    tick();
    nvec++;
    if (ivalid_h !== 1'b1 || iaddr_h !== 32'hFFFF_FFF8) begin
      nmiss++;
      $display("FAIL wrap_restart got v=%b a=%h exp v=1 a=fffffff8", ivalid_h, iaddr_h);
    end
  endtask

  initial begin
    rst_h = 1'b1; rdy_h = 1'b1; jv_h = 1'b0; ja_h = 32'h0000_0000;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_misalign();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
